// File: rtl/pwm_duty_meter.sv
// PWM period / high-time meter: measures sig_in in clk cycles, classifies duty into
// 20/40/60/80 % bins and flags loss of signal after 2^CW-1 cycles without an edge.
module pwm_duty_meter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sig_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic [1:0]    duty_code,
  output logic          valid,
  output logic          timeout,
  output logic          locked
);

  localparam int unsigned MW = CW + 4;
  localparam logic [CW-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic          rise_q, rise_d, fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CW-1:0] period_q, period_d, high_time_q, high_time_d;
  logic [1:0]    duty_q, duty_d, duty_calc;
  logic          valid_q, valid_d, timeout_q, timeout_d, locked_q, locked_d;
  logic [CW-1:0] cnt_inc;
  logic [MW-1:0] h10, p3, p5, p7;

  // 10*H against 3P/5P/7P replaces a divide when binning the duty ratio.
  always_comb begin
    h10 = MW'(hcnt_q) * MW'(10);
    p3  = MW'(cnt_q) * MW'(3);
    p5  = MW'(cnt_q) * MW'(5);
    p7  = MW'(cnt_q) * MW'(7);
    if (h10 < p3) begin
      duty_calc = 2'b00;
    end else if (h10 < p5) begin
      duty_calc = 2'b01;
    end else if (h10 < p7) begin
      duty_calc = 2'b10;
    end else begin
      duty_calc = 2'b11;
    end
  end

  always_comb begin
    sync1_d     = sig_in;
    sync2_d     = sync1_q;
    hist_d      = sync2_q;
    // Edge strobes are registered so the FSM decode stays off the synchronizer path.
    rise_d      = sync2_q & ~hist_q;
    fall_d      = ~sync2_q & hist_q;
    cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1);
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    duty_d      = duty_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    locked_d    = locked_q;
    unique case (state_q)
      StIdle: begin
        if (rise_q) begin
          cnt_d   = CW'(1);
          state_d = StHigh;
        end else begin
          cnt_d = '0;
        end
      end
      StHigh: begin
        if (fall_q) begin
          hcnt_d  = cnt_q;
          cnt_d   = cnt_inc;
          state_d = StLow;
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StLow: begin
        if (rise_q) begin
          period_d    = cnt_q;
          high_time_d = hcnt_q;
          duty_d      = duty_calc;
          valid_d     = 1'b1;
          locked_d    = 1'b1;
          cnt_d       = CW'(1);
          state_d     = StHigh;
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      hist_q      <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      duty_q      <= 2'b00;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      locked_q    <= locked_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign duty_code = duty_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomized bench for pwm_duty_meter: a timestamp-based reference model predicts every
// output each cycle, plus directed checks on the characteristic waveforms.
module tb_pwm_duty_meter;

  localparam int CW = 8;
  localparam int NS = 60000;
  localparam int TMAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period, high_time;
  logic [1:0]    duty_code;
  logic          valid, timeout, locked;

  pwm_duty_meter #(.CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .duty_code (duty_code),
    .valid     (valid),
    .timeout   (timeout),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit samp [NS];

  // Reference model: timestamps of the last rise/fall as the block sees them.
  bit m_meas, m_high;
  int rise_t, fall_t;
  int e_period, e_high, e_duty;
  bit e_valid, e_to, e_locked;

  int n_valid, n_to, first_valid_cyc, last_to_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit sget(input int i);
    if (i < 0 || i >= NS) return 1'b0;
    return samp[i];
  endfunction

  function automatic int duty_of(input int p, input int h);
    if (10 * h < 3 * p) return 0;
    if (10 * h < 5 * p) return 1;
    if (10 * h < 7 * p) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_meas = 0; m_high = 0; rise_t = 0; fall_t = 0;
    e_period = 0; e_high = 0; e_duty = 0;
    e_valid = 0; e_to = 0; e_locked = 0;
    for (int i = cyc - 4; i <= cyc; i++) if (i >= 0 && i < NS) samp[i] = 1'b0;
  endtask

  // An input transition sampled at edge n acts on the outputs at edge n+3.
  task automatic model_edge();
    bit r, f;
    int d;
    r = sget(cyc - 3) && !sget(cyc - 4);
    f = !sget(cyc - 3) && sget(cyc - 4);
    d = cyc - rise_t;
    e_valid = 0;
    e_to = 0;
    if (!m_meas) begin
      if (r) begin m_meas = 1; m_high = 1; rise_t = cyc; end
    end else if (m_high) begin
      if (f) begin m_high = 0; fall_t = cyc; end
      else if (d >= TMAX) begin e_to = 1; e_locked = 0; m_meas = 0; end
    end else begin
      if (r) begin
        e_valid = 1; e_locked = 1;
        e_period = d; e_high = fall_t - rise_t; e_duty = duty_of(e_period, e_high);
        rise_t = cyc; m_high = 1;
      end else if (d >= TMAX) begin
        e_to = 1; e_locked = 0; m_meas = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", 32'(valid), 32'(e_valid));
    check_eq("timeout", 32'(timeout), 32'(e_to));
    check_eq("locked", 32'(locked), 32'(e_locked));
    check_eq("period", 32'(period), 32'(e_period));
    check_eq("high_time", 32'(high_time), 32'(e_high));
    check_eq("duty_code", 32'(duty_code), 32'(e_duty));
  endtask

  task automatic step(input logic v);
    sig_in = v;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      if (cyc < NS) samp[cyc] = v;
      model_edge();
    end
    check_outputs();
    if (valid) begin
      n_valid++;
      if (n_valid == 1) first_valid_cyc = cyc;
    end
    if (timeout) begin
      n_to++;
      last_to_cyc = cyc;
    end
  endtask

  task automatic pwm(input int p, input int h, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < p; j++) step(j < h);
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  // Asynchronous assertion between edges; outputs must clear at once.
  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    hold(1'b0, n);
    rst = 1'b0;
  endtask

  task automatic clear_counts();
    n_valid = 0; n_to = 0; first_valid_cyc = -1; last_to_cyc = -1;
  endtask

  initial begin
    int c0, p, h;
    model_reset();
    #1;
    check_outputs();
    hold(1'b0, 3);
    rst = 1'b0;

    // Stable 5/2 stream.
    clear_counts();
    pwm(5, 2, 10);
    check_eq("s52_valids", 32'(n_valid), 32'd9);
    check_eq("s52_period", 32'(period), 32'd5);
    check_eq("s52_high", 32'(high_time), 32'd2);
    check_eq("s52_duty", 32'(duty_code), 32'd1);
    check_eq("s52_locked", 32'(locked), 32'd1);

    // Duty switching at P=5.
    pwm(5, 1, 6);
    check_eq("sw_duty20", 32'(duty_code), 32'd0);
    pwm(5, 3, 6);
    check_eq("sw_duty60", 32'(duty_code), 32'd2);
    pwm(5, 4, 6);
    check_eq("sw_duty80", 32'(duty_code), 32'd3);

    // Loss of signal low, then a single rise held high.
    hold(1'b0, 300);
    clear_counts();
    c0 = cyc + 1;
    hold(1'b1, 300);
    check_eq("to_count", 32'(n_to), 32'd1);
    check_eq("to_valids", 32'(n_valid), 32'd0);
    check_eq("to_latency", 32'(last_to_cyc - c0), 32'd258);
    check_eq("to_locked", 32'(locked), 32'd0);
    check_eq("to_period", 32'(period), 32'd5);
    check_eq("to_high", 32'(high_time), 32'd4);
    check_eq("to_duty", 32'(duty_code), 32'd3);
    hold(1'b0, 10);

    // Square wave after reset: first valid 3 edges after the second rise is sampled.
    do_reset(3);
    clear_counts();
    c0 = cyc + 1;
    pwm(10, 5, 5);
    check_eq("sq_first_valid", 32'(first_valid_cyc - c0), 32'd13);
    check_eq("sq_period", 32'(period), 32'd10);
    check_eq("sq_high", 32'(high_time), 32'd5);
    check_eq("sq_duty", 32'(duty_code), 32'd2);

    // Reset in the middle of a high phase.
    hold(1'b1, 2);
    do_reset(2);
    clear_counts();
    c0 = cyc + 1;
    pwm(10, 5, 3);
    check_eq("rst_first_valid", 32'(first_valid_cyc - c0), 32'd13);
    check_eq("rst_period", 32'(period), 32'd10);

    // Longest legal period: rise coincides with the counter ceiling.
    clear_counts();
    pwm(255, 100, 3);
    check_eq("p255_timeouts", 32'(n_to), 32'd0);
    check_eq("p255_period", 32'(period), 32'd255);
    check_eq("p255_high", 32'(high_time), 32'd100);
    check_eq("p255_duty", 32'(duty_code), 32'd1);

    // Random periods, occasional long periods and signal-loss gaps.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 19) == 0) p = $urandom_range(200, 255);
      else p = $urandom_range(2, 80);
      h = $urandom_range(1, p - 1);
      pwm(p, h, 1);
      if ($urandom_range(0, 29) == 0) hold(1'b0, $urandom_range(260, 300));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
